// File: rtl/adder_slice_sched.sv
// Round-robin scheduler for one shared, enable-gated 1-bit adder slice.
// Each granted request runs a WIDTH-bit add through the slice, LSB first.
// The carry between bit positions is kept in this block.
module adder_slice_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_a,
  input  logic [NREQ*WIDTH-1:0] i_b,
  output logic [NREQ-1:0]       o_gnt,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [IDW-1:0]        o_id,
  output logic [WIDTH-1:0]      o_sum,
  output logic                  o_cout,
  output logic                  o_slice_en,
  output logic                  o_slice_a,
  output logic                  o_slice_b,
  output logic                  o_slice_cin,
  input  logic                  i_slice_sum,
  input  logic                  i_slice_cout
);

  localparam int unsigned      CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [IDW-1:0]    oid_q, oid_d;
  logic [WIDTH-1:0]  osum_q, osum_d;
  logic              cout_q, cout_d;

  logic              found;
  logic [IDW-1:0]    winner;
  int unsigned       idx;
  logic [WIDTH-1:0]  a_sel, b_sel;
  logic [IDW-1:0]    ptr_nxt;
  logic [NREQ-1:0]   gnt_oh;

  // Round-robin search: first set request at or above the pointer, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr_q) + i) % NREQ;
      if (!found && i_req[IDW'(idx)]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  // Operand mux for the winning requester, plus grant/pointer derivations.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (winner == IDW'(k)) begin
        a_sel = i_a[k*WIDTH +: WIDTH];
        b_sel = i_b[k*WIDTH +: WIDTH];
      end
    end
    ptr_nxt = IDW'((32'(winner) + 1) % NREQ);
    gnt_oh  = NREQ'(1) << winner;
  end

  // Next-state and registered-output logic for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    id_d    = id_q;
    gnt_d   = '0;
    busy_d  = busy_q;
    valid_d = 1'b0;
    oid_d   = oid_q;
    osum_d  = osum_q;
    cout_d  = cout_q;

    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StRun;
          gnt_d   = gnt_oh;
          a_d     = a_sel;
          b_d     = b_sel;
          id_d    = winner;
          ptr_d   = ptr_nxt;
          cnt_d   = '0;
          carry_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StRun: begin
        sum_d[cnt_q] = i_slice_sum;
        carry_d      = i_slice_cout;
        cnt_d        = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          valid_d = 1'b1;
          osum_d  = sum_d;
          cout_d  = i_slice_cout;
          oid_d   = id_q;
        end
      end
      StDone: begin
        // Result strobe lasts one cycle; arbitration resumes in IDLE.
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      oid_q   <= '0;
      osum_q  <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      oid_q   <= oid_d;
      osum_q  <= osum_d;
      cout_q  <= cout_d;
    end
  end

  // Slice drive is decoded from state so the slice is quiet outside RUN.
  always_comb begin
    o_slice_en  = (state_q == StRun);
    o_slice_a   = o_slice_en & a_q[cnt_q];
    o_slice_b   = o_slice_en & b_q[cnt_q];
    o_slice_cin = o_slice_en & carry_q;
  end

  assign o_gnt   = gnt_q;
  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_id    = oid_q;
  assign o_sum   = osum_q;
  assign o_cout  = cout_q;

endmodule

// File: tb/tb_adder_slice_sched.sv
// Bench for adder_slice_sched: scenario tasks plus a randomized round-robin run
// checked against an arithmetic/queue-free reference of the arbitration rules.
module tb_adder_slice_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic [7:0]       opa [4];
  logic [7:0]       opb [4];
  logic [31:0]      ia, ib;
  logic [3:0]       o_gnt;
  logic             o_busy, o_valid, o_cout;
  logic [1:0]       o_id;
  logic [7:0]       o_sum;
  logic             o_slice_en, o_slice_a, o_slice_b, o_slice_cin;
  logic             slice_sum, slice_cout;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int mptr = 0;

  assign ia = {opa[3], opa[2], opa[1], opa[0]};
  assign ib = {opb[3], opb[2], opb[1], opb[0]};

  // External enable-gated full-adder slice.
  assign slice_sum  = o_slice_en & (o_slice_a ^ o_slice_b ^ o_slice_cin);
  assign slice_cout = o_slice_en & ((o_slice_a & o_slice_b) | (o_slice_a & o_slice_cin) |
                                    (o_slice_b & o_slice_cin));

  adder_slice_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req        (req),
    .i_a          (ia),
    .i_b          (ib),
    .o_gnt        (o_gnt),
    .o_busy       (o_busy),
    .o_valid      (o_valid),
    .o_id         (o_id),
    .o_sum        (o_sum),
    .o_cout       (o_cout),
    .o_slice_en   (o_slice_en),
    .o_slice_a    (o_slice_a),
    .o_slice_b    (o_slice_b),
    .o_slice_cin  (o_slice_cin),
    .i_slice_sum  (slice_sum),
    .i_slice_cout (slice_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    rst  = 1'b0;
    mptr = 0;
  endtask

  function automatic int rr_pick(int p, logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  // Waits for a grant, follows the operation to its result strobe and reports what it saw.
  task automatic run_op(input bit keep, output logic [3:0] g, output int gtime, output int lat,
                        output int en_cnt, output logic [7:0] cins, output logic [7:0] s,
                        output logic c, output logic [1:0] id, output bit prot_ok,
                        output bit ok);
    int w;
    ok = 1'b1; prot_ok = 1'b1; en_cnt = 0; lat = 0; cins = '0;
    g = '0; gtime = 0; s = '0; c = 1'b0; id = '0; w = 0;
    do begin
      step();
      w++;
    end while (o_gnt == 4'b0000 && w < 30);
    if (o_gnt == 4'b0000) begin
      ok = 1'b0;
      return;
    end
    g = o_gnt;
    gtime = cyc;
    if (!keep) req = req & ~o_gnt;
    while (!o_valid && lat < 30) begin
      if (o_slice_en) begin
        if (en_cnt < 8) cins[en_cnt] = o_slice_cin;
        en_cnt++;
      end
      if (!o_busy) prot_ok = 1'b0;
      if (lat > 0 && o_gnt != 4'b0000) prot_ok = 1'b0;
      step();
      lat++;
    end
    if (!o_valid) begin
      ok = 1'b0;
      return;
    end
    if (!o_busy || o_slice_en || o_gnt != 4'b0000) prot_ok = 1'b0;
    s = o_sum; c = o_cout; id = o_id;
  endtask

  logic [3:0] g;
  int         gtime, lat, en_cnt;
  logic [7:0] cins, s;
  logic       c;
  logic [1:0] id;
  bit         prot_ok, ok;

  task automatic test_reset();
    rst = 1'b1;
    req = 4'hF;
    step();
    step();
    nvec++;
    if ({o_gnt, o_busy, o_valid, o_id, o_sum, o_cout} !== 18'h0) begin
      nerr++;
      $display("FAIL reset_regs: got gnt=%b busy=%b valid=%b id=%0d sum=%h cout=%b, want all 0",
               o_gnt, o_busy, o_valid, o_id, o_sum, o_cout);
    end
    nvec++;
    if ({o_slice_en, o_slice_a, o_slice_b, o_slice_cin} !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_slice: got %b want 0000",
               {o_slice_en, o_slice_a, o_slice_b, o_slice_cin});
    end
    rst = 1'b0;
    req = '0;
    mptr = 0;
    step();
  endtask

  task automatic test_single();
    opa[1] = 8'h35; opb[1] = 8'h4A;
    req = 4'b0010;
    run_op(1'b0, g, gtime, lat, en_cnt, cins, s, c, id, prot_ok, ok);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL single_timeout: got no grant/valid, want completion");
      return;
    end
    nvec++;
    if (g !== 4'b0010) begin nerr++; $display("FAIL single_gnt: got %b want 0010", g); end
    nvec++;
    if (lat !== 8) begin nerr++; $display("FAIL single_latency: got %0d want 8", lat); end
    nvec++;
    if (en_cnt !== 8) begin nerr++; $display("FAIL single_en_cnt: got %0d want 8", en_cnt); end
    nvec++;
    if ({c, s} !== 9'h07F || id !== 2'd1) begin
      nerr++;
      $display("FAIL single_result: got cout=%b sum=%h id=%0d want 0 7f 1", c, s, id);
    end
    nvec++;
    if (!prot_ok) begin nerr++; $display("FAIL single_protocol: got 0 want 1"); end
    step(); step(); step();
    nvec++;
    if (o_sum !== 8'h7F || o_id !== 2'd1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
      nerr++;
      $display("FAIL single_hold: got sum=%h id=%0d valid=%b busy=%b want 7f 1 0 0",
               o_sum, o_id, o_valid, o_busy);
    end
  endtask

  task automatic test_overflow();
    opa[0] = 8'hFF; opb[0] = 8'h01;
    req = 4'b0001;
    run_op(1'b0, g, gtime, lat, en_cnt, cins, s, c, id, prot_ok, ok);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL ovf_timeout: got no grant/valid, want completion");
      return;
    end
    nvec++;
    if ({c, s} !== 9'h100 || id !== 2'd0) begin
      nerr++;
      $display("FAIL ovf_result: got cout=%b sum=%h id=%0d want 1 00 0", c, s, id);
    end
    nvec++;
    if (cins !== 8'hFE) begin nerr++; $display("FAIL ovf_cin_seq: got %b want 11111110", cins); end
  endtask

  task automatic test_round_robin();
    int prev;
    logic [8:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      opa[i] = 8'($urandom); opb[i] = 8'($urandom);
    end
    req = 4'hF;
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      run_op(1'b1, g, gtime, lat, en_cnt, cins, s, c, id, prot_ok, ok);
      if (i == 5) req = '0;
      nvec++;
      if (!ok) begin
        nerr++;
        $display("FAIL rr_timeout: op %0d got no completion, want completion", i);
        req = '0;
        return;
      end
      e = {1'b0, opa[i % 4]} + {1'b0, opb[i % 4]};
      nvec++;
      if (g !== (4'b0001 << (i % 4))) begin
        nerr++;
        $display("FAIL rr_order: op %0d got %b want %b", i, g, 4'b0001 << (i % 4));
      end
      nvec++;
      if ({c, s} !== e) begin
        nerr++;
        $display("FAIL rr_result: op %0d got %h want %h", i, {c, s}, e);
      end
      if (i > 0) begin
        nvec++;
        if (gtime - prev !== 10) begin
          nerr++;
          $display("FAIL rr_spacing: op %0d got %0d want 10", i, gtime - prev);
        end
      end
      prev = gtime;
    end
    step(); step(); step();
  endtask

  task automatic test_pointer();
    logic [3:0] want [3];
    want[0] = 4'b0100; want[1] = 4'b1000; want[2] = 4'b0001;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      opa[i] = 8'($urandom); opb[i] = 8'($urandom);
    end
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, g, gtime, lat, en_cnt, cins, s, c, id, prot_ok, ok);
      if (i == 0) req = 4'b1001;
      nvec++;
      if (!ok || g !== want[i]) begin
        nerr++;
        $display("FAIL ptr_order: step %0d got %b (ok=%0d) want %b", i, g, ok, want[i]);
      end
    end
    req = '0;
    step(); step();
  endtask

  task automatic test_reset_mid();
    int w;
    int nval;
    logic [8:0] e;
    do_reset();
    opa[0] = 8'($urandom); opb[0] = 8'($urandom);
    req = 4'b0001;
    w = 0;
    do begin
      step();
      w++;
    end while (o_gnt == 4'b0000 && w < 30);
    req = '0;
    nvec++;
    if (o_gnt !== 4'b0001) begin nerr++; $display("FAIL rmid_gnt: got %b want 0001", o_gnt); end
    step(); step(); step(); step();
    rst = 1'b1;
    step();
    nvec++;
    if ({o_valid, o_busy, o_slice_en, o_sum} !== 11'h000) begin
      nerr++;
      $display("FAIL rmid_abort: got valid=%b busy=%b en=%b sum=%h want 0 0 0 00",
               o_valid, o_busy, o_slice_en, o_sum);
    end
    rst = 1'b0;
    mptr = 0;
    nval = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_valid || o_busy) nval++;
      step();
    end
    nvec++;
    if (nval !== 0) begin nerr++; $display("FAIL rmid_quiet: got %0d active cycles want 0", nval); end
    opa[0] = 8'($urandom); opb[0] = 8'($urandom);
    e = {1'b0, opa[0]} + {1'b0, opb[0]};
    req = 4'b0001;
    run_op(1'b0, g, gtime, lat, en_cnt, cins, s, c, id, prot_ok, ok);
    nvec++;
    if (!ok || g !== 4'b0001 || {c, s} !== e || id !== 2'd0) begin
      nerr++;
      $display("FAIL rmid_after: got ok=%0d gnt=%b res=%h id=%0d want 1 0001 %h 0",
               ok, g, {c, s}, id, e);
    end
  endtask

  task automatic test_late();
    int w, vtime;
    logic [8:0] e0;
    do_reset();
    opa[0] = 8'($urandom); opb[0] = 8'($urandom);
    e0 = {1'b0, opa[0]} + {1'b0, opb[0]};
    req = 4'b0001;
    w = 0;
    do begin
      step();
      w++;
    end while (o_gnt == 4'b0000 && w < 30);
    req = '0;
    step(); step(); step();
    opa[2] = 8'h10; opb[2] = 8'h20;
    req = 4'b0100;
    w = 0;
    while (!o_valid && w < 30) begin
      step();
      w++;
    end
    vtime = cyc;
    nvec++;
    if (!o_valid || {o_cout, o_sum} !== e0 || o_id !== 2'd0) begin
      nerr++;
      $display("FAIL late_first: got valid=%b res=%h id=%0d want 1 %h 0",
               o_valid, {o_cout, o_sum}, o_id, e0);
    end
    run_op(1'b0, g, gtime, lat, en_cnt, cins, s, c, id, prot_ok, ok);
    nvec++;
    if (!ok || g !== 4'b0100 || gtime - vtime !== 2) begin
      nerr++;
      $display("FAIL late_gnt: got ok=%0d gnt=%b delay=%0d want 1 0100 2",
               ok, g, gtime - vtime);
    end
    nvec++;
    if ({c, s} !== 9'h030 || id !== 2'd2) begin
      nerr++;
      $display("FAIL late_result: got res=%h id=%0d want 030 2", {c, s}, id);
    end
  endtask

  task automatic test_random();
    logic [3:0] nb;
    logic [8:0] e;
    int w;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      if (req == 4'b0000) begin
        nb = 4'($urandom_range(1, 15));
        for (int i = 0; i < 4; i++) begin
          if (nb[i]) begin opa[i] = 8'($urandom); opb[i] = 8'($urandom); end
        end
        req = nb;
      end
      w = rr_pick(mptr, req);
      run_op(1'b0, g, gtime, lat, en_cnt, cins, s, c, id, prot_ok, ok);
      nvec++;
      if (!ok) begin
        nerr++;
        $display("FAIL rand_timeout: op %0d got no completion want completion", n);
        req = '0;
        return;
      end
      e = {1'b0, opa[w]} + {1'b0, opb[w]};
      nvec++;
      if (g !== (4'b0001 << w)) begin
        nerr++;
        $display("FAIL rand_gnt: op %0d got %b want %b", n, g, 4'b0001 << w);
      end
      nvec++;
      if ({c, s} !== e || id !== 2'(w)) begin
        nerr++;
        $display("FAIL rand_result: op %0d got res=%h id=%0d want %h %0d", n, {c, s}, id, e, w);
      end
      nvec++;
      if (lat !== 8 || en_cnt !== 8 || !prot_ok) begin
        nerr++;
        $display("FAIL rand_timing: op %0d got lat=%0d en=%0d prot=%0d want 8 8 1",
                 n, lat, en_cnt, prot_ok);
      end
      mptr = (w + 1) % 4;
      nb = 4'($urandom_range(0, 15)) & ~req;
      for (int i = 0; i < 4; i++) begin
        if (nb[i]) begin opa[i] = 8'($urandom); opb[i] = 8'($urandom); end
      end
      req = req | nb;
    end
    req = '0;
    step(); step(); step();
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < 4; i++) begin opa[i] = '0; opb[i] = '0; end
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_pointer();
    test_reset_mid();
    test_late();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of run, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
